// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcode, state and flag types for seq_alu
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_SHL = 3'b101,
    OP_SHR = 3'b110,
    OP_MUL = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic c;
    logic z;
    logic n;
    logic v;
  } flags_t;

endpackage

// File: rtl/alu_comb_core.sv
// rtl/alu_comb_core.sv - combinational single-cycle ops and flag generation
module alu_comb_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  op_e              op,
  output logic [WIDTH-1:0] y,
  output flags_t           flags
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;
  logic           c;
  logic           v;

  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};

  always_comb begin
    y = '0;
    c = 1'b0;
    v = 1'b0;
    case (op)
      OP_ADD: begin
        y = sum[WIDTH-1:0];
        c = sum[WIDTH];
        v = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        // The extra top bit of the widened difference is the unsigned borrow.
        y = diff[WIDTH-1:0];
        c = diff[WIDTH];
        v = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND: y = a & b;
      OP_OR:  y = a | b;
      OP_XOR: y = a ^ b;
      OP_SHL: begin
        y = {a[WIDTH-2:0], 1'b0};
        c = a[WIDTH-1];
      end
      OP_SHR: begin
        y = {1'b0, a[WIDTH-1:1]};
        c = a[0];
      end
      default: y = '0;
    endcase
  end

  assign flags = '{c: c, z: (y == '0), n: y[WIDTH-1], v: v};

endmodule

// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - registered ALU with valid/ready handshake and shift-add multiplier
module seq_alu
  import alu_pkg::*;
#(
  parameter  int WIDTH = 4,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] y_hi,
  output logic             flag_c,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_v
);

  state_e             state_q;
  logic [WIDTH-1:0]   y_q;
  logic [WIDTH-1:0]   y_hi_q;
  flags_t             flags_q;
  logic [WIDTH-1:0]   mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] acc_d;
  logic [CNT_W-1:0]   cnt_q;

  logic [WIDTH-1:0]   core_y;
  flags_t             core_flags;
  op_e                op_in;

  assign op_in = op_e'(op);

  alu_comb_core #(.WIDTH(WIDTH)) u_core (
    .a     (a),
    .b     (b),
    .op    (op_in),
    .y     (core_y),
    .flags (core_flags)
  );

  assign acc_d = mplier_q[0] ? acc_q + ({{WIDTH{1'b0}}, mcand_q} << cnt_q) : acc_q;

  // Counter reaching WIDTH costs one extra BUSY cycle to register the product.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      y_q      <= '0;
      y_hi_q   <= '0;
      flags_q  <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            if (op_in == OP_MUL) begin
              mcand_q  <= a;
              mplier_q <= b;
              acc_q    <= '0;
              cnt_q    <= '0;
              state_q  <= BUSY;
            end else begin
              y_q     <= core_y;
              y_hi_q  <= '0;
              flags_q <= core_flags;
              state_q <= DONE;
            end
          end
        end
        BUSY: begin
          if (cnt_q == CNT_W'(WIDTH)) begin
            y_q     <= acc_q[WIDTH-1:0];
            y_hi_q  <= acc_q[2*WIDTH-1:WIDTH];
            flags_q <= '{c: 1'b0, z: (acc_q == '0), n: acc_q[WIDTH-1], v: 1'b0};
            state_q <= DONE;
          end else begin
            acc_q    <= acc_d;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + CNT_W'(1);
          end
        end
        DONE: begin
          if (out_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign y         = y_q;
  assign y_hi      = y_hi_q;
  assign flag_c    = flags_q.c;
  assign flag_z    = flags_q.z;
  assign flag_n    = flags_q.n;
  assign flag_v    = flags_q.v;

endmodule

// File: tb/tb_seq_alu.sv
// tb/tb_seq_alu.sv - directed self-checking bench for seq_alu
module tb_seq_alu;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] a;
  logic [3:0] b;
  logic [2:0] op;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] y;
  logic [3:0] y_hi;
  logic       flag_c, flag_z, flag_n, flag_v;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  seq_alu #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .y_hi      (y_hi),
    .flag_c    (flag_c),
    .flag_z    (flag_z),
    .flag_n    (flag_n),
    .flag_v    (flag_v)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] ta, input logic [3:0] tb_v, input logic [2:0] top);
    int n;
    n = 0;
    a = ta; b = tb_v; op = top; in_valid = 1'b1;
    while (!in_ready && n < 20) begin
      step();
      n++;
    end
    chk("issue_ready", 16'(in_ready), 16'd1);
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (!out_valid && n < 20) begin
      step();
      n++;
    end
    chk(tag, 16'(out_valid), 16'd1);
  endtask

  task automatic release_result(input string tag);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({tag, "_ov_drop"}, 16'(out_valid), 16'd0);
    chk({tag, "_ready_back"}, 16'(in_ready), 16'd1);
  endtask

  function automatic logic [15:0] fl();
    return 16'({flag_c, flag_z, flag_n, flag_v});
  endfunction

  logic [2:0] t_op [5] = '{3'b010, 3'b011, 3'b100, 3'b101, 3'b110};
  logic [3:0] t_y  [5] = '{4'b1000, 4'b1011, 4'b0011, 4'b0010, 4'b0100};
  logic [3:0] t_fl [5] = '{4'b0010, 4'b0010, 4'b0000, 4'b1000, 4'b1000};
  int seen_valid;

  initial begin
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; op = '0; out_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
    chk("rst_in_ready", 16'(in_ready), 16'd1);
    chk("rst_out_valid", 16'(out_valid), 16'd0);
    chk("rst_y", 16'(y), 16'd0);
    chk("rst_y_hi", 16'(y_hi), 16'd0);
    chk("rst_flags", fl(), 16'd0);

    // ADD with carry and signed overflow, latency 1
    issue(4'b1001, 4'b1010, 3'b000);
    chk("add_ov", 16'(out_valid), 16'd1);
    chk("add_in_ready", 16'(in_ready), 16'd0);
    chk("add_y", 16'(y), 16'h3);
    chk("add_y_hi", 16'(y_hi), 16'h0);
    chk("add_flags_cznv", fl(), 16'b1001);
    release_result("add");

    issue(4'b1001, 4'b1010, 3'b001);
    chk("sub_ov", 16'(out_valid), 16'd1);
    chk("sub_y", 16'(y), 16'hF);
    chk("sub_flags_cznv", fl(), 16'b1010);
    release_result("sub");

    // MUL: valid exactly WIDTH+1 cycles after the accept edge
    issue(4'b1001, 4'b1010, 3'b111);
    for (int k = 1; k <= 4; k++) begin
      chk($sformatf("mul_busy_ready_%0d", k), 16'(in_ready), 16'd0);
      chk($sformatf("mul_busy_ov_%0d", k), 16'(out_valid), 16'd0);
      step();
    end
    step();
    chk("mul_ov_at_5", 16'(out_valid), 16'd1);
    chk("mul_y", 16'(y), 16'hA);
    chk("mul_y_hi", 16'(y_hi), 16'h5);
    chk("mul_flags_cznv", fl(), 16'b0010);
    release_result("mul");

    for (int i = 0; i < 5; i++) begin
      issue(4'b1001, 4'b1010, t_op[i]);
      chk($sformatf("op%0d_ov", t_op[i]), 16'(out_valid), 16'd1);
      chk($sformatf("op%0d_y", t_op[i]), 16'(y), 16'(t_y[i]));
      chk($sformatf("op%0d_flags", t_op[i]), fl(), 16'(t_fl[i]));
      chk($sformatf("op%0d_y_hi", t_op[i]), 16'(y_hi), 16'h0);
      release_result("logic");
    end

    issue(4'b0101, 4'b1010, 3'b010);
    chk("and_zero_y", 16'(y), 16'h0);
    chk("and_zero_flags", fl(), 16'b0100);
    release_result("and_zero");

    issue(4'b1111, 4'b0001, 3'b000);
    chk("add_wrap_y", 16'(y), 16'h0);
    chk("add_wrap_flags", fl(), 16'b1100);
    release_result("add_wrap");

    issue(4'b0000, 4'b0111, 3'b111);
    wait_valid("mul0_valid");
    chk("mul0_y", 16'(y), 16'h0);
    chk("mul0_y_hi", 16'(y_hi), 16'h0);
    chk("mul0_flags", fl(), 16'b0100);
    release_result("mul0");

    issue(4'b1111, 4'b1111, 3'b111);
    wait_valid("mulmax_valid");
    chk("mulmax_y", 16'(y), 16'h1);
    chk("mulmax_y_hi", 16'(y_hi), 16'hE);
    chk("mulmax_flags", fl(), 16'b0000);
    release_result("mulmax");

    // Back-pressure: result held while a new request waits
    issue(4'b1001, 4'b1010, 3'b000);
    a = 4'b0001; b = 4'b0001; op = 3'b000; in_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("bp_ov_%0d", k), 16'(out_valid), 16'd1);
      chk($sformatf("bp_in_ready_%0d", k), 16'(in_ready), 16'd0);
      chk($sformatf("bp_y_%0d", k), 16'(y), 16'h3);
      chk($sformatf("bp_flags_%0d", k), fl(), 16'b1001);
      step();
    end
    in_valid = 1'b0;
    release_result("bp");
    chk("bp_y_kept_idle", 16'(y), 16'h3);
    step();
    chk("bp_no_second_accept", 16'(out_valid), 16'd0);

    // Reset during BUSY discards the multiply
    issue(4'b1001, 4'b1010, 3'b111);
    step();
    rst = 1'b1;
    #1;
    chk("rstbusy_ov", 16'(out_valid), 16'd0);
    chk("rstbusy_in_ready", 16'(in_ready), 16'd1);
    chk("rstbusy_y", 16'(y), 16'h0);
    chk("rstbusy_y_hi", 16'(y_hi), 16'h0);
    chk("rstbusy_flags", fl(), 16'd0);
    step();
    rst = 1'b0;
    seen_valid = 0;
    for (int k = 0; k < 8; k++) begin
      if (out_valid) seen_valid++;
      step();
    end
    chk("rstbusy_never_valid", 16'(seen_valid), 16'd0);
    chk("rstbusy_ready_after", 16'(in_ready), 16'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
Parametrised, registered successor to the 4-bit combinational ALU. It takes operands and an opcode through a valid/ready handshake and returns a result with status flags. Single-cycle ops complete in one clock. MUL runs as a multi-cycle shift-add sequence. Used as a shared arithmetic engine behind a simple controller or datapath.

Parameters:
WIDTH, 4, operand and result width (>= 2)
CNT_W, $clog2(WIDTH)+1, width of the multiply iteration counter (derived, not overridden)

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
in_valid  input  1  operand/opcode presented
in_ready  output  1  block can accept a new operation
a  input  WIDTH  operand A (unsigned; signed view for the V flag)
b  input  WIDTH  operand B
op  input  3  opcode, see Behaviour
out_valid  output  1  result held and valid
out_ready  input  1  consumer accepts result
y  output  WIDTH  result; low half for MUL
y_hi  output  WIDTH  high half of the MUL product; 0 for all other ops
flag_c  output  1  carry / borrow / shifted-out bit
flag_z  output  1  y == 0 (for MUL: the full 2*WIDTH product == 0)
flag_n  output  1  y[WIDTH-1]
flag_v  output  1  signed overflow (ADD/SUB only, else 0)

Behaviour:
- Opcodes:
  - 000 ADD: {c,y} = a+b
  - 001 SUB: y = a-b, c = borrow (a<b unsigned)
  - 010 AND
  - 011 OR
  - 100 XOR
  - 101 SHL by 1: c = a[MSB]
  - 110 SHR logical by 1: c = a[0]
  - 111 MUL, unsigned, 2*WIDTH product
- C is 0 for AND/OR/XOR/MUL.
- V for ADD: sign(a)==sign(b) and sign(y)!=sign(a). V for SUB: sign(a)!=sign(b) and sign(y)!=sign(a).
- Reset: state IDLE, in_ready=1, out_valid=0, y=0, y_hi=0, all flags=0, counter=0.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: in_ready=1. An accept is in_valid && in_ready at a clock edge. Operands and op are latched on accept.
    - Non-MUL op: compute and register results at that same edge; go to DONE. out_valid rises the cycle after accept (latency 1).
    - MUL: load multiplicand, multiplier, 2*WIDTH accumulator=0, counter=0; go to BUSY.
  - BUSY: in_ready=0. Each cycle: if multiplier LSB is 1, add multiplicand<<counter into the accumulator; shift multiplier right; counter+1. After WIDTH iterations, register y/y_hi/flags and go to DONE. out_valid rises WIDTH+1 cycles after the accept edge.
  - DONE: out_valid=1, in_ready=0.
    - y, y_hi and flags hold stable while out_valid && !out_ready.
    - On out_ready, go to IDLE. out_valid drops next cycle.
    - No accept in the same cycle: one op in flight at a time.
- in_valid while in_ready=0 is ignored; the source must hold it.
- Outputs y/y_hi/flags keep their last value in IDLE; only out_valid qualifies them.
- Reset asserted mid-BUSY or in DONE: immediately returns to the reset values; the in-flight op is discarded.
- op decode is registered at accept; later changes to a, b or op have no effect on the in-flight op.
- Boundaries:
  - WIDTH-bit wrap on ADD/SUB.
  - MUL by 0 gives Z=1.
  - Max operands give full-width product (2^WIDTH-1)^2 without loss.

Decomposition:
- Shared package alu_pkg:
  - op_e enum (OP_ADD..OP_MUL, 3-bit)
  - state_e enum (IDLE, BUSY, DONE)
  - flags_t packed struct {c, z, n, v}
- One natural sub-module: alu_comb_core. Purely combinational single-cycle ops and flag generation, parameterised by WIDTH.
- The top holds the FSM, the operand/result registers and the shift-add multiplier.

Test Plan:
All scenarios use WIDTH=4.
1. Reset then idle: rst high for 2 cycles -> in_ready=1, out_valid=0, y=0000, flags=0.
2. a=1001, b=1010, op=000 -> one cycle later y=0011, C=1, V=1, Z=0, N=0, y_hi=0000.
3. a=1001, b=1010, op=001 -> y=1111, C=1, N=1, V=0.
4. a=1001, b=1010, op=111 -> in_ready low for 4 BUSY cycles; out_valid 5 cycles after accept; y=1010, y_hi=0101 (90); Z=0.
5. Ops 010, 011, 100, 101, 110 with a=1001, b=1010 -> y=1000, 1011, 0011, 0010 (C=1), 0100 (C=1). Then a=0101, b=1010, op=010 -> y=0000, Z=1.
6. Back-pressure and reset:
   - Hold out_ready=0 for 6 cycles after an ADD -> y/flags stable, in_ready=0, a second in_valid is not accepted.
   - Start a MUL and assert rst on BUSY cycle 2 -> out_valid never rises, all outputs 0, in_ready=1 after reset release.
